sevenseg_capture: RTL and testbench
===================================

# sevenseg_capture

Seven-segment capture decoder: samples a multiplexed, active-high seven-segment bus (digit strobe plus segment lines) and recovers the hexadecimal digit shown on each position. It is the inverse of the team's hex-to-segment encoder. On-board loopback and self-check use it to read back what the display path is driving. Each pattern must be stable for a fixed number of cycles before it is committed, so strobe transitions and glitches are never captured.

## Interface
- DIGITS, 4, number of display positions (>=1)
- STABLE_CYCLES, 4, consecutive identical samples required before commit (>=1)

- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- seg_in  in  7  active-high segments, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
- an_in  in  DIGITS  active-high digit strobe, expected one-hot; bit i selects position i
- clear  in  1  synchronous clear of all captured state
- value_out  out  4*DIGITS  captured nibble per position; position i at [4i+3:4i]
- valid_out  out  DIGITS  position holds a committed hex digit
- err_out  out  DIGITS  position last saw a non-hex, non-blank pattern
- update  out  1  one-cycle pulse when any value_out/valid_out bit changes

## Operation
- Input register: {an_in, seg_in} is sampled into a register every cycle.
- Stability counter:
  - Width is clog2(STABLE_CYCLES+1).
  - Counts consecutive cycles where the sampled value equals the previous sample.
  - Reloads to 1 when the sample differs.
  - Saturates at STABLE_CYCLES.
- Commit event: fires only on the cycle the counter reaches STABLE_CYCLES, so exactly one commit per stable run. Holding the inputs longer never re-commits.
- Commit ignored (no state change) if the sampled an is not one-hot, i.e. zero or multiple bits set.
- Decode table, active-high seg to nibble:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3
  - 0110011=4, 1011011=5, 1011111=6, 1110000=7
  - 1111111=8, 1111011=9, 1110111=A, 0011111=b
  - 1001110=C, 0111101=d, 1001111=E, 1000111=F
- Commit to position i:
  - Table hit: value[i] <= nibble, valid[i] <= 1, err[i] <= 0.
  - Blank (0000000): valid[i] <= 0, err[i] <= 0, value[i] held.
  - Any other pattern: err[i] <= 1, valid[i] <= 0, value[i] held.
- update pulses on a commit that changes value[i] or valid[i]. Re-committing an identical digit (a new stable run with the same pattern) produces no pulse.
- clear:
  - Zeroes value_out, valid_out, err_out and the stability counter.
  - Resets the input register to all-zero.
  - Forces update=0.
  - Wins over a coincident commit.
- Positions other than the strobed one are never modified.

## Timing
- Reset (async, immediate): value_out=0, valid_out=0, err_out=0, update=0, counter=0, input register=0.
- Latency: inputs held constant across sampling edges t0..t0+STABLE_CYCLES-1. value_out/valid_out/err_out update at edge t0+STABLE_CYCLES-1 and are visible after it. update is high for that same following cycle only.
- STABLE_CYCLES=1: every sample that differs from its predecessor commits.
- Reset deasserted mid-run: capture restarts from the empty state. The first commit needs a full STABLE_CYCLES run.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 immediately; after release with an_in=0 for 20 cycles -> outputs stay 0, no update.
- Basic commit (DIGITS=4, STABLE_CYCLES=4): an_in=0001, seg_in=1111110 held 4 edges -> value_out[3:0]=0, valid_out=0001, one update pulse. Hold 10 more cycles -> no further pulse.
- Full table sweep: an_in=0100, each of the 16 patterns held 4 cycles in order 0..F -> value_out[11:8] steps 0x0..0xF, 16 update pulses, err_out=0.
- Glitch rejection: an_in=0010, seg_in=0110000 held 3 cycles, then 1111110 held 4 -> value_out[7:4]=0, valid_out[1]=1; digit 1 is never captured.
- Errors, blank and bad strobe, on position 3:
  - 1010101 for 4 cycles -> err_out[3]=1, valid_out[3]=0, value held.
  - Then 1111111 -> value_out[15:12]=8, err_out[3]=0.
  - Then 0000000 -> valid_out[3]=0, err_out[3]=0.
  - an_in=0011 with any pattern -> no change.
- Clear priority: clear asserted on the same cycle a commit would occur -> all outputs 0, update=0. Re-present the pattern -> commit after 4 more cycles.

Source files
------------

// File: rtl/sevenseg_capture.sv
// Seven-segment capture decoder: recovers the hex digit on each multiplexed
// display position once a {strobe, segments} pattern has been stable long enough.
module sevenseg_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [DIGITS-1:0]     valid_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  update
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = DIGITS + 7;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        PAT_HEX,
        PAT_BLANK,
        PAT_BAD
    } pat_kind_t;

    typedef struct packed {
        pat_kind_t  kind;
        logic [3:0] nibble;
    } pat_t;

    function automatic pat_t decode(input logic [6:0] seg);
        pat_t p;
        p.kind   = PAT_HEX;
        p.nibble = 4'h0;
        case (seg)
            7'b1111110: p.nibble = 4'h0;
            7'b0110000: p.nibble = 4'h1;
            7'b1101101: p.nibble = 4'h2;
            7'b1111001: p.nibble = 4'h3;
            7'b0110011: p.nibble = 4'h4;
            7'b1011011: p.nibble = 4'h5;
            7'b1011111: p.nibble = 4'h6;
            7'b1110000: p.nibble = 4'h7;
            7'b1111111: p.nibble = 4'h8;
            7'b1111011: p.nibble = 4'h9;
            7'b1110111: p.nibble = 4'hA;
            7'b0011111: p.nibble = 4'hB;
            7'b1001110: p.nibble = 4'hC;
            7'b0111101: p.nibble = 4'hD;
            7'b1001111: p.nibble = 4'hE;
            7'b1000111: p.nibble = 4'hF;
            7'b0000000: p.kind   = PAT_BLANK;
            default:    p.kind   = PAT_BAD;
        endcase
        return p;
    endfunction

    logic [SW-1:0]         samp;
    logic [SW-1:0]         cur;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic                  diff;
    logic                  commit;
    logic                  onehot;
    pat_t                  pat;
    logic [4*DIGITS-1:0]   value_next;
    logic [DIGITS-1:0]     valid_next;
    logic [DIGITS-1:0]     err_next;
    logic                  update_next;

    assign cur    = {an_in, seg_in};
    assign onehot = (an_in != '0) && ((an_in & (an_in - 1'b1)) == '0);
    assign pat    = decode(seg_in);

    // The comparison uses the live inputs against the last sample so a run
    // held across STABLE_CYCLES edges commits on its final edge.
    always_comb begin
        diff = (cur != samp);
        if (diff)
            cnt_next = CW'(1);
        else if (cnt == CNT_MAX)
            cnt_next = cnt;
        else
            cnt_next = cnt + CW'(1);
        commit = (cnt_next == CNT_MAX) && (diff || (cnt != CNT_MAX));
    end

    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        value_next = value_out;
        valid_next = valid_out;
        err_next   = err_out;
        if (commit && onehot) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (an_in[i]) begin
                    case (pat.kind)
                        PAT_HEX: begin
                            value_next[4*i +: 4] = pat.nibble;
                            valid_next[i]        = 1'b1;
                            err_next[i]          = 1'b0;
                        end
                        PAT_BLANK: begin
                            valid_next[i] = 1'b0;
                            err_next[i]   = 1'b0;
                        end
                        default: begin
                            valid_next[i] = 1'b0;
                            err_next[i]   = 1'b1;
                        end
                    endcase
                end
            end
        end
        update_next = (value_next != value_out) || (valid_next != valid_out);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp      <= '0;
            cnt       <= '0;
            value_out <= '0;
            valid_out <= '0;
            err_out   <= '0;
            update    <= 1'b0;
        end else if (clear) begin
            samp      <= '0;
            cnt       <= '0;
            value_out <= '0;
            valid_out <= '0;
            err_out   <= '0;
            update    <= 1'b0;
        end else begin
            samp      <= cur;
            cnt       <= cnt_next;
            value_out <= value_next;
            valid_out <= valid_next;
            err_out   <= err_next;
            update    <= update_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture (DIGITS=4, STABLE_CYCLES=4): table of
// held patterns with expected state, plus reset and clear corner sequences.
module tb_sevenseg_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic        clear;
    logic [15:0] value_out;
    logic [3:0]  valid_out;
    logic [3:0]  err_out;
    logic        update;

    int n_cmp = 0;
    int n_bad = 0;

    sevenseg_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .an_in     (an_in),
        .clear     (clear),
        .value_out (value_out),
        .valid_out (valid_out),
        .err_out   (err_out),
        .update    (update)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] exp_value;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_err;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance n rising edges, sampling outputs 1ns after each, counting update pulses.
    task automatic run(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (update === 1'b1) pulses++;
        end
    endtask

    task automatic check_state(input string name, input logic [15:0] v,
                               input logic [3:0] vl, input logic [3:0] e);
        check({name, ".value"}, 32'(value_out), 32'(v));
        check({name, ".valid"}, 32'(valid_out), 32'(vl));
        check({name, ".err"},   32'(err_out),   32'(e));
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] an, input logic [6:0] seg,
                                input int hold, input logic [15:0] v, input logic [3:0] vl,
                                input logic [3:0] e, input int p);
        vec_t r;
        r.name = name; r.an = an; r.seg = seg; r.hold = hold;
        r.exp_value = v; r.exp_valid = vl; r.exp_err = e; r.exp_pulses = p;
        return r;
    endfunction

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    initial begin
        int pulses;

        vecs.push_back(mk("basic0",    4'b0001, 7'h7E, 4,  16'h0000, 4'b0001, 4'b0000, 1));
        vecs.push_back(mk("hold10",    4'b0001, 7'h7E, 10, 16'h0000, 4'b0001, 4'b0000, 0));
        for (int k = 0; k < 16; k++)
            vecs.push_back(mk($sformatf("sweep%0h", k), 4'b0100, seg_tab[k], 4,
                              16'(k) << 8, 4'b0101, 4'b0000, 1));
        vecs.push_back(mk("glitch1",   4'b0010, 7'h30, 3,  16'h0F00, 4'b0101, 4'b0000, 0));
        vecs.push_back(mk("glitch0",   4'b0010, 7'h7E, 4,  16'h0F00, 4'b0111, 4'b0000, 1));
        vecs.push_back(mk("bad_pat",   4'b1000, 7'h55, 4,  16'h0F00, 4'b0111, 4'b1000, 0));
        vecs.push_back(mk("eight",     4'b1000, 7'h7F, 4,  16'h8F00, 4'b1111, 4'b0000, 1));
        vecs.push_back(mk("blank",     4'b1000, 7'h00, 4,  16'h8F00, 4'b0111, 4'b0000, 1));
        vecs.push_back(mk("two_hot",   4'b0011, 7'h30, 4,  16'h8F00, 4'b0111, 4'b0000, 0));
        vecs.push_back(mk("no_strobe", 4'b0000, 7'h7E, 4,  16'h8F00, 4'b0111, 4'b0000, 0));
        vecs.push_back(mk("recommit",  4'b0001, 7'h7E, 4,  16'h8F00, 4'b0111, 4'b0000, 0));

        rst = 1'b1; clear = 1'b0; an_in = '0; seg_in = '0;
        #12;
        check_state("in_reset", 16'h0, 4'h0, 4'h0);
        check("in_reset.update", 32'(update), 32'd0);
        #5 rst = 1'b0;

        run(20, pulses);
        check_state("idle20", 16'h0, 4'h0, 4'h0);
        check("idle20.pulses", 32'(pulses), 32'd0);

        foreach (vecs[i]) begin
            an_in  = vecs[i].an;
            seg_in = vecs[i].seg;
            run(vecs[i].hold, pulses);
            check_state(vecs[i].name, vecs[i].exp_value, vecs[i].exp_valid, vecs[i].exp_err);
            check({vecs[i].name, ".pulses"}, 32'(pulses), 32'(vecs[i].exp_pulses));
        end

        // Clear coincident with the commit edge wins.
        an_in = 4'b0001; seg_in = 7'h30;
        run(3, pulses);
        check("pre_clear.pulses", 32'(pulses), 32'd0);
        clear = 1'b1;
        run(1, pulses);
        check_state("clear", 16'h0, 4'h0, 4'h0);
        check("clear.update", 32'(update), 32'd0);
        clear = 1'b0;
        run(3, pulses);
        check_state("post_clear3", 16'h0, 4'h0, 4'h0);
        check("post_clear3.pulses", 32'(pulses), 32'd0);
        run(1, pulses);
        check_state("post_clear4", 16'h0001, 4'b0001, 4'h0);
        check("post_clear4.update", 32'(update), 32'd1);

        // Reset asserted mid-run: immediate clear, then a full run is needed.
        an_in = 4'b0010; seg_in = 7'h6D;
        run(2, pulses);
        rst = 1'b1;
        #1;
        check_state("mid_reset", 16'h0, 4'h0, 4'h0);
        check("mid_reset.update", 32'(update), 32'd0);
        #3 rst = 1'b0;
        run(3, pulses);
        check_state("restart3", 16'h0, 4'h0, 4'h0);
        check("restart3.pulses", 32'(pulses), 32'd0);
        run(1, pulses);
        check_state("restart4", 16'h0020, 4'b0010, 4'h0);
        check("restart4.pulses", 32'(pulses), 32'd1);
        run(1, pulses);
        check("restart5.update", 32'(update), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
